// File: rtl/mac_sat_drain.sv
// mac_sat_drain: saturate MAC output words and buffer them in a FIFO with valid/ready drain
//
// Captures each 40-bit {protect,result} word from the MAC, clips it to a
// 32-bit word (single mode) or two independent 16-bit lanes (dual mode), and
// queues {sat,data} in a DEPTH-entry FIFO. mac_stall is raised early enough
// that STALL_MARGIN words still in flight are absorbed without overflow.
//
// Optional feature: define MAC_DRAIN_SATCNT_EN to add a 16-bit saturating
// counter of pushed words that were clipped (port sat_count).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   new MAC word on protect/result this cycle
//   in_dual    0 = one 32-bit word, 1 = two 16-bit lanes
//   protect    8 MAC guard bits
//   result     32 MAC result bits
//   mac_stall  registered stall request to the MAC
//   out_data   saturated word at the FIFO head
//   out_sat    head word was clipped (any lane)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes head when out_valid && out_ready
//   overflow   sticky: a word arrived while the FIFO was full
//   clr_ovf    synchronous clear of overflow (and sat_count)
//   sat_count  (MAC_DRAIN_SATCNT_EN only) count of clipped pushes
module mac_sat_drain #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_dual,
    input  logic [7:0]  protect,
    input  logic [31:0] result,
    output logic        mac_stall,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        clr_ovf
`ifdef MAC_DRAIN_SATCNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // A 20-bit lane fits in 16 bits only when its top five bits are all equal.
    function automatic logic [16:0] sat20(input logic [19:0] x);
        logic clip;
        clip = !((&x[19:15]) || !(|x[19:15]));
        return {clip, clip ? (x[19] ? 16'h8000 : 16'h7FFF) : x[15:0]};
    endfunction

    logic [39:0] w_v;
    logic        w_s_clip;
    logic [31:0] w_s_data;
    logic [16:0] w_hi;
    logic [16:0] w_lo;
    logic [31:0] w_in_data;
    logic        w_in_sat;

    assign w_v       = {protect, result};
    assign w_s_clip  = !((&w_v[39:31]) || !(|w_v[39:31]));
    assign w_s_data  = w_s_clip ? (w_v[39] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_v[31:0];
    assign w_hi      = sat20({protect[7:4], result[31:16]});
    assign w_lo      = sat20({protect[3:0], result[15:0]});
    assign w_in_data = in_dual ? {w_hi[15:0], w_lo[15:0]} : w_s_data;
    assign w_in_sat  = in_dual ? (w_hi[16] | w_lo[16]) : w_s_clip;

    logic [32:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [31:0]   r_data;
    logic          r_sat;
    logic          r_stall;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_rd_next;
    logic          w_head_new;

    assign w_full       = r_count == CW'(DEPTH);
    assign w_empty      = r_count == '0;
    assign w_push       = in_valid && !w_full;
    assign w_pop        = !w_empty && out_ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rd_next    = r_rd + PW'(w_pop);
    // Nothing left after this edge's pop: the incoming word becomes the head
    // directly, since it is not readable from the array until after the edge.
    assign w_head_new   = (r_count - CW'(w_pop)) == '0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_in_sat, w_in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_sat   <= 1'b0;
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wr    <= r_wr + PW'(w_push);
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            r_stall <= (CW'(DEPTH) - w_count_next) <= CW'(STALL_MARGIN);
            r_ovf   <= clr_ovf ? 1'b0 : (r_ovf || (in_valid && w_full));
            // Head register keeps its last value once the FIFO drains empty.
            if (w_count_next != '0)
                {r_sat, r_data} <= w_head_new ? {w_in_sat, w_in_data} : r_mem[w_rd_next];
        end
    end

`ifdef MAC_DRAIN_SATCNT_EN
    logic [15:0] r_sat_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat_count <= '0;
        else if (clr_ovf)
            r_sat_count <= '0;
        else if (w_push && w_in_sat && r_sat_count != 16'hFFFF)
            r_sat_count <= r_sat_count + 16'd1;
    end
    assign sat_count = r_sat_count;
`endif

    assign mac_stall = r_stall;
    assign out_data  = r_data;
    assign out_sat   = r_sat;
    assign out_valid = !w_empty;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_mac_sat_drain.sv
// tb_mac_sat_drain: table-driven saturation vectors plus FIFO fill/drain, overflow and reset sequences
module tb_mac_sat_drain;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_dual;
    logic [7:0]  protect;
    logic [31:0] result;
    logic        mac_stall;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        clr_ovf;

    int checks = 0;
    int failures = 0;

    mac_sat_drain #(.DEPTH(8), .STALL_MARGIN(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_dual(in_dual),
        .protect(protect), .result(result), .mac_stall(mac_stall),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dual;
        logic [7:0]  prot;
        logic [31:0] res;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h12345678, 32'h12345678, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 32'h80000000, 32'h7FFFFFFF, 1'b1};
        vecs[3]  = '{1'b0, 8'hFF, 32'h80000000, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b0, 8'hFF, 32'h7FFFFFFF, 32'h80000000, 1'b1};
        vecs[5]  = '{1'b0, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{1'b0, 8'h80, 32'h00000000, 32'h80000000, 1'b1};
        vecs[7]  = '{1'b0, 8'h7F, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1};
        vecs[8]  = '{1'b1, 8'h0F, 32'h00017FFF, 32'h00018000, 1'b1};
        vecs[9]  = '{1'b1, 8'h00, 32'h7FFF8000, 32'h7FFF7FFF, 1'b1};
        vecs[10] = '{1'b1, 8'hFF, 32'h80007FFF, 32'h80008000, 1'b1};
        vecs[11] = '{1'b1, 8'h10, 32'h12345678, 32'h7FFF5678, 1'b1};
        vecs[12] = '{1'b1, 8'h00, 32'h12345678, 32'h12345678, 1'b0};
        vecs[13] = '{1'b1, 8'hF0, 32'hFFFF0001, 32'hFFFF0001, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_dual = 1'b0; protect = '0;
        result = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_stall", 32'(mac_stall), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            in_dual = vecs[i].dual; protect = vecs[i].prot; result = vecs[i].res;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_sat", i), 32'(out_sat), 32'(vecs[i].exp_sat));
        end
        @(negedge clk);
        chk("drained_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_dual = 1'b0; protect = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            result = 32'(k);
            @(negedge clk);
            chk($sformatf("fill%0d_stall", k), 32'(mac_stall), 32'(k >= 6));
            chk($sformatf("fill%0d_ovf", k), 32'(overflow), 32'(k >= 9));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_data", k), out_data, 32'(k));
            @(negedge clk);
            chk($sformatf("drain%0d_stall", k), 32'(mac_stall), 32'(k <= 2));
        end
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_hold", out_data, 32'd8);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        out_ready = 1'b0; clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf0", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            result = 32'h100 + 32'(k);
            @(negedge clk);
        end
        chk("full_stall", 32'(mac_stall), 32'd1);
        chk("full_ovf", 32'(overflow), 32'd0);
        result = 32'hAA; out_ready = 1'b1;
        @(negedge clk);
        chk("pp_full_ovf", 32'(overflow), 32'd1);
        chk("pp_full_head", out_data, 32'h102);
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b1;
        @(negedge clk);
        chk("clr_ovf1", 32'(overflow), 32'd0);
        clr_ovf = 1'b0; in_valid = 1'b1; result = 32'hBB;
        @(negedge clk);
        chk("refill_ovf", 32'(overflow), 32'd0);
        result = 32'hCC; clr_ovf = 1'b1;
        @(negedge clk);
        chk("clr_priority", 32'(overflow), 32'd0);
        clr_ovf = 1'b0; result = 32'hDD;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_again", 32'(overflow), 32'd1);
        chk("head_before_rst", out_data, 32'h102);

        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_stall", 32'(mac_stall), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; result = 32'h55; protect = 8'h00; in_dual = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", out_data, 32'h55);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
